// File: rtl/if_stage_fetch_queue_if.sv
// Instruction-memory read bus between the fetch stage (master) and a
// synchronous read-only instruction memory (slave). The memory returns
// rdata one cycle after a cycle in which req was high.
interface if_stage_fetch_queue_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
);
    logic                   req;
    logic [PC_WIDTH-1:0]    addr;
    logic [INSTR_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rdata
    );
endinterface

// File: rtl/if_stage_fetch_queue.sv
// Instruction fetch stage: PC generation, synchronous instruction-memory
// fetch with one-cycle latency, a QUEUE_DEPTH-entry fetch queue that
// decouples memory latency from ID stalls, and the IF/ID pipeline register.
// Branch redirect flushes the queue and drops any in-flight response.
module if_stage_fetch_queue #(
    parameter int              PC_WIDTH    = 8,
    parameter int              INSTR_WIDTH = 32,
    parameter int              PC_INC      = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            BranchTaken,
    input  logic [PC_WIDTH-1:0]             BranchTarget,
    input  logic                            ID_Stall,
    if_stage_fetch_queue_if.master          imem,
    output logic [INSTR_WIDTH-1:0]          IF_ID_Instruction,
    output logic [PC_WIDTH-1:0]             IF_ID_PC,
    output logic                            IF_ID_Valid,
    output logic [$clog2(QUEUE_DEPTH):0]    q_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PC_WIDTH-1:0] INC   = PC_WIDTH'(PC_INC);
    localparam logic [CW:0]         DEPTH = (CW + 1)'(QUEUE_DEPTH);

    // Architectural state
    logic [PC_WIDTH-1:0]    fetch_pc_reg,      fetch_pc_next;
    logic                   inflight_v_reg,    inflight_v_next;
    logic [PC_WIDTH-1:0]    inflight_addr_reg, inflight_addr_next;
    logic [PW-1:0]          head_reg,          head_next;
    logic [PW-1:0]          tail_reg,          tail_next;
    logic [CW-1:0]          count_reg,         count_next;
    logic [INSTR_WIDTH-1:0] if_id_instr_reg,   if_id_instr_next;
    logic [PC_WIDTH-1:0]    if_id_pc_reg,      if_id_pc_next;
    logic                   if_id_valid_reg,   if_id_valid_next;

    // Queue storage: instruction word plus its return PC (address + PC_INC)
    logic [INSTR_WIDTH-1:0] q_instr_mem [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]    q_pc_mem    [QUEUE_DEPTH];

    logic                   req;
    logic                   push_en;
    logic                   pop_en;
    logic [PC_WIDTH-1:0]    push_pc;

    // Credit check uses registered occupancy only, so a push can never
    // overflow even when the queue is not popped in the response cycle.
    always_comb begin
        req = !rst &&
              (({1'b0, count_reg} + {{CW{1'b0}}, inflight_v_reg}) < DEPTH);
    end

    assign imem.req  = req;
    assign imem.addr = fetch_pc_reg;
    assign push_pc   = inflight_addr_reg + INC;

    // Next-state logic: branch flush has priority over push, pop and stall
    always_comb begin
        fetch_pc_next      = fetch_pc_reg;
        inflight_v_next    = inflight_v_reg;
        inflight_addr_next = inflight_addr_reg;
        head_next          = head_reg;
        tail_next          = tail_reg;
        count_next         = count_reg;
        if_id_instr_next   = if_id_instr_reg;
        if_id_pc_next      = if_id_pc_reg;
        if_id_valid_next   = if_id_valid_reg;
        push_en            = 1'b0;
        pop_en             = 1'b0;

        if (BranchTaken) begin
            // Any request issued this cycle is dropped with the in-flight slot
            fetch_pc_next    = BranchTarget;
            inflight_v_next  = 1'b0;
            head_next        = '0;
            tail_next        = '0;
            count_next       = '0;
            if_id_valid_next = 1'b0;
            if_id_instr_next = '0;
        end else begin
            push_en = inflight_v_reg;
            pop_en  = !ID_Stall && (count_reg != '0);

            if (req) begin
                fetch_pc_next      = fetch_pc_reg + INC;
                inflight_v_next    = 1'b1;
                inflight_addr_next = fetch_pc_reg;
            end else begin
                inflight_v_next    = 1'b0;
            end

            if (push_en) begin
                tail_next = tail_reg + PW'(1);
            end

            if (!ID_Stall) begin
                if (pop_en) begin
                    head_next        = head_reg + PW'(1);
                    if_id_instr_next = q_instr_mem[head_reg];
                    if_id_pc_next    = q_pc_mem[head_reg];
                    if_id_valid_next = 1'b1;
                end else begin
                    // Empty queue: inject a bubble, keep the last PC
                    if_id_instr_next = '0;
                    if_id_valid_next = 1'b0;
                end
            end

            case ({push_en, pop_en})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // State register with synchronous reset taking priority over branch
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg      <= RESET_PC;
            inflight_v_reg    <= 1'b0;
            inflight_addr_reg <= '0;
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            if_id_instr_reg   <= '0;
            if_id_pc_reg      <= '0;
            if_id_valid_reg   <= 1'b0;
        end else begin
            fetch_pc_reg      <= fetch_pc_next;
            inflight_v_reg    <= inflight_v_next;
            inflight_addr_reg <= inflight_addr_next;
            head_reg          <= head_next;
            tail_reg          <= tail_next;
            count_reg         <= count_next;
            if_id_instr_reg   <= if_id_instr_next;
            if_id_pc_reg      <= if_id_pc_next;
            if_id_valid_reg   <= if_id_valid_next;
        end
    end

    // Queue write port: the memory response lands at the tail slot
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            q_instr_mem[tail_reg] <= imem.rdata;
            q_pc_mem[tail_reg]    <= push_pc;
        end
    end

    assign IF_ID_Instruction = if_id_instr_reg;
    assign IF_ID_PC          = if_id_pc_reg;
    assign IF_ID_Valid       = if_id_valid_reg;
    assign q_count           = count_reg;

endmodule

// File: tb/tb_if_stage_fetch_queue.sv
// Testbench for if_stage_fetch_queue: directed scenarios followed by random
// stall/branch/reset traffic, checked every cycle against a queue-based
// reference model of the fetch pipeline.
module tb_if_stage_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [7:0]  RESET_PC = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [7:0]  tgt;
    logic        stall;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic [2:0]  q_count;

    if_stage_fetch_queue_if #(.PC_WIDTH(8), .INSTR_WIDTH(32)) imem_bus ();

    if_stage_fetch_queue #(
        .PC_WIDTH(8), .INSTR_WIDTH(32), .PC_INC(4),
        .RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .BranchTaken       (br),
        .BranchTarget      (tgt),
        .ID_Stall          (stall),
        .imem              (imem_bus.master),
        .IF_ID_Instruction (if_id_instr),
        .IF_ID_PC          (if_id_pc),
        .IF_ID_Valid       (if_id_valid),
        .q_count           (q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return 32'hA000_0000 | {24'h0, a};
    endfunction

    // ROM: one-cycle latency read-only memory
    always_ff @(posedge clk) begin
        if (imem_bus.req) imem_bus.rdata <= rom_word(imem_bus.addr);
    end

    // Reference model state
    logic [7:0]  m_fpc;
    logic        m_inf_v;
    logic [7:0]  m_inf_addr;
    logic [7:0]  m_q[$];
    logic        m_out_v;
    logic [31:0] m_out_instr;
    logic [7:0]  m_out_pc;

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs with the model,
    // then advance the model across the coming rising edge.
    task automatic step(input logic r, input logic b, input logic [7:0] t,
                        input logic s);
        logic       exp_req;
        logic [7:0] a;
        @(negedge clk);
        rst = r; br = b; tgt = t; stall = s;
        #1;
        exp_req = !r && ((m_q.size() + int'(m_inf_v)) < DEPTH);
        check_val("valid",   {31'h0, if_id_valid}, {31'h0, m_out_v});
        check_val("instr",   if_id_instr, m_out_instr);
        check_val("pc",      {24'h0, if_id_pc}, {24'h0, m_out_pc});
        check_val("q_count", {29'h0, q_count}, m_q.size());
        check_val("req",     {31'h0, imem_bus.req}, {31'h0, exp_req});
        if (exp_req) check_val("addr", {24'h0, imem_bus.addr}, {24'h0, m_fpc});
        if (m_out_v && !s)
            $display("t=%0t deliver instr=%h pc=%h", $time, m_out_instr, m_out_pc);

        if (r) begin
            m_fpc = RESET_PC; m_inf_v = 1'b0; m_q.delete();
            m_out_v = 1'b0; m_out_instr = '0; m_out_pc = '0;
        end else if (b) begin
            m_q.delete(); m_inf_v = 1'b0; m_fpc = t;
            m_out_v = 1'b0; m_out_instr = '0;
        end else begin
            if (!s) begin
                if (m_q.size() > 0) begin
                    a = m_q.pop_front();
                    m_out_v = 1'b1; m_out_instr = rom_word(a); m_out_pc = a + 8'd4;
                end else begin
                    m_out_v = 1'b0; m_out_instr = '0;
                end
            end
            if (m_inf_v) m_q.push_back(m_inf_addr);
            if (exp_req) begin
                m_inf_v = 1'b1; m_inf_addr = m_fpc; m_fpc = m_fpc + 8'd4;
            end else begin
                m_inf_v = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; br = 1'b0; tgt = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        m_fpc = RESET_PC; m_inf_v = 1'b0; m_q.delete();
        m_out_v = 1'b0; m_out_instr = '0; m_out_pc = '0;

        // Reset values, then start-up latency and steady stream
        step(1, 0, 8'h00, 0);
        repeat (10) step(0, 0, 8'h00, 0);

        // Long stall fills the queue and stops requests
        repeat (6) step(0, 0, 8'h00, 1);
        check_val("stall_full", {29'h0, q_count}, 32'd4);
        repeat (8) step(0, 0, 8'h00, 0);

        // Branch with a partly filled queue
        repeat (2) step(0, 0, 8'h00, 1);
        step(0, 1, 8'h40, 0);
        repeat (6) step(0, 0, 8'h00, 0);

        // Branch during stall while a response is in flight
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h80, 1);
        repeat (6) step(0, 0, 8'h00, 0);

        // Address wrap at the top of the PC range
        step(0, 1, 8'hF8, 0);
        repeat (8) step(0, 0, 8'h00, 0);

        // Mid-run reset with a full queue, then restart
        repeat (6) step(0, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(1, 1, 8'h20, 0);
        repeat (6) step(0, 0, 8'h00, 0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 8),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 35));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
